wb_addr_gen: RTL and testbench

Write-back address generator for the systolic-array output path. It mirrors the operand read-address selector on the write side. After a start pulse it waits out the fixed array latency, then walks a write serial number. For each of two output SRAM groups (columns 0–3, columns 4–7, with group 1 skewed by GROUP_SKEW cycles) it produces a registered write address, an active-low write enable and the registered result word. It sits between the array's result columns and the output SRAMs, and reports busy/done to the top-level controller.

---
 rtl/wb_addr_gen.sv | 132 +++++++++++++
 tb/tb_wb_addr_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_addr_gen.sv
// Write-back address generator: after a start pulse waits out the array latency, then
// emits registered SRAM write enable/address/data for two column groups, group 1 skewed.
module wb_addr_gen #(
    parameter int ARRAY_LAT  = 16,
    parameter int NUM_WORDS  = 99,
    parameter int GROUP_SKEW = 4,
    parameter int ADDR_W     = 10,
    parameter int DW         = 32,
    parameter int IDLE_ADDR  = 127
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              start,
    input  logic [4*DW-1:0]   result_g0,
    input  logic [4*DW-1:0]   result_g1,
    output logic              sram_wen_a0,
    output logic [ADDR_W-1:0] sram_waddr_a0,
    output logic [4*DW-1:0]   sram_wdata_a0,
    output logic              sram_wen_a1,
    output logic [ADDR_W-1:0] sram_waddr_a1,
    output logic [4*DW-1:0]   sram_wdata_a1,
    output logic              busy,
    output logic              done
);

    localparam int SW = 7;
    localparam int CW = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(ARRAY_LAT - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(NUM_WORDS + GROUP_SKEW - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [SW-1:0]   s_reg, s_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic [4*DW-1:0] result [2];
    assign result[0] = result_g0;
    assign result[1] = result_g1;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            s_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
        end
    end

    // The done pulse falls in an IDLE cycle; a start coinciding with it is dropped.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        case (state_reg)
            IDLE: begin
                if (start && !done_reg) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end
            end
            WAIT: begin
                s_next = '0;
                if (cnt_reg == '0) state_next = WRITE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            WRITE: begin
                s_next = s_reg + 1'b1;
                if (s_reg == S_LAST) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_grp
        localparam logic [SW-1:0] OFF = SW'(gi * GROUP_SKEW);
        logic [SW-1:0]     rel;
        logic              hit;
        logic              wen_reg;
        logic [ADDR_W-1:0] addr_reg;
        logic [4*DW-1:0]   data_reg;

        // rel wraps high when s < OFF; NUM_WORDS+GROUP_SKEW <= 127 keeps that out of range.
        always_comb begin
            rel = s_reg - OFF;
            hit = (state_reg == WRITE) && (rel < SW'(NUM_WORDS));
        end

        always_ff @(posedge clk) begin
            if (!srstn) begin
                wen_reg  <= 1'b1;
                addr_reg <= ADDR_W'(IDLE_ADDR);
                data_reg <= '0;
            end else begin
                wen_reg  <= !hit;
                addr_reg <= hit ? ADDR_W'(rel) : ADDR_W'(IDLE_ADDR);
                if (hit) data_reg <= result[gi];
            end
        end
    end

    assign sram_wen_a0   = g_grp[0].wen_reg;
    assign sram_waddr_a0 = g_grp[0].addr_reg;
    assign sram_wdata_a0 = g_grp[0].data_reg;
    assign sram_wen_a1   = g_grp[1].wen_reg;
    assign sram_waddr_a1 = g_grp[1].addr_reg;
    assign sram_wdata_a1 = g_grp[1].data_reg;

endmodule

// File: tb/tb_wb_addr_gen.sv
// Directed bench for wb_addr_gen: default instance plus a short-latency instance,
// checked cycle by cycle against a timing model built from the start/reset stimulus.
module tb_wb_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         srstn, start_a, start_b;
    logic [127:0] res0, res1;

    logic         wen0_a, wen1_a, busy_a, done_a;
    logic [9:0]   addr0_a, addr1_a;
    logic [127:0] data0_a, data1_a;
    logic         wen0_b, wen1_b, busy_b, done_b;
    logic [9:0]   addr0_b, addr1_b;
    logic [127:0] data0_b, data1_b;

    wb_addr_gen dut_a (
        .clk(clk), .srstn(srstn), .start(start_a),
        .result_g0(res0), .result_g1(res1),
        .sram_wen_a0(wen0_a), .sram_waddr_a0(addr0_a), .sram_wdata_a0(data0_a),
        .sram_wen_a1(wen1_a), .sram_waddr_a1(addr1_a), .sram_wdata_a1(data1_a),
        .busy(busy_a), .done(done_a)
    );

    wb_addr_gen #(.ARRAY_LAT(1), .NUM_WORDS(4), .GROUP_SKEW(0)) dut_b (
        .clk(clk), .srstn(srstn), .start(start_b),
        .result_g0(res0), .result_g1(res1),
        .sram_wen_a0(wen0_b), .sram_waddr_a0(addr0_b), .sram_wdata_a0(data0_b),
        .sram_wen_a1(wen1_b), .sram_waddr_a1(addr1_b), .sram_wdata_a1(data1_b),
        .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    logic [127:0] exp_d0 [2];
    logic [127:0] exp_d1 [2];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_results();
        gcyc++;
        res0 = {32'hA000_0000 | gcyc, 32'hA100_0000 | gcyc, 32'hA200_0000 | gcyc, 32'hA300_0000 | gcyc};
        res1 = {32'hB000_0000 | gcyc, 32'hB100_0000 | gcyc, 32'hB200_0000 | gcyc, 32'hB300_0000 | gcyc};
    endtask

    // Starts a run, then for each cycle k (k=1 is the cycle after the start edge) checks
    // all outputs. hold: start stays high while k<hold; pulse_at/rst_at: one-cycle events.
    task automatic run(input int sel, input int lat, input int n, input int skew,
                       input int hold, input int pulse_at, input int rst_at, input int window,
                       output int writes0, output int writes1, output int dones);
        int rs, dk, i0, i1;
        logic v0, v1, st;
        logic ow0, ow1, ob, od;
        logic [9:0] oa0, oa1;
        logic [127:0] odat0, odat1;
        writes0 = 0; writes1 = 0; dones = 0;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        rs = 1;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (sel == 0) begin
                ow0 = wen0_a; oa0 = addr0_a; odat0 = data0_a;
                ow1 = wen1_a; oa1 = addr1_a; odat1 = data1_a;
                ob = busy_a; od = done_a;
            end else begin
                ow0 = wen0_b; oa0 = addr0_b; odat0 = data0_b;
                ow1 = wen1_b; oa1 = addr1_b; odat1 = data1_b;
                ob = busy_b; od = done_b;
            end
            dk = rs + lat + skew + n + 1;
            i0 = k - rs - lat - 1;
            i1 = i0 - skew;
            v0 = (rs > 0) && (i0 >= 0) && (i0 < n);
            v1 = (rs > 0) && (i1 >= 0) && (i1 < n);
            if (v0) exp_d0[sel] = res0;
            if (v1) exp_d1[sel] = res1;
            chk("wen_a0",   ow0,   !v0);
            chk("waddr_a0", oa0,   v0 ? i0 : 127);
            chk("wdata_a0", odat0, exp_d0[sel]);
            chk("wen_a1",   ow1,   !v1);
            chk("waddr_a1", oa1,   v1 ? i1 : 127);
            chk("wdata_a1", odat1, exp_d1[sel]);
            chk("busy",     ob,    (rs > 0) && (k < dk));
            chk("done",     od,    (rs > 0) && (k == dk));
            writes0 += (ow0 === 1'b0) ? 1 : 0;
            writes1 += (ow1 === 1'b0) ? 1 : 0;
            dones   += (od === 1'b1) ? 1 : 0;
            drive_results();
            srstn = (k == rst_at) ? 1'b0 : 1'b1;
            st = (k < hold) || (k == pulse_at);
            if (sel == 0) start_a = st; else start_b = st;
            if (!srstn) begin
                rs = 0;
                for (int j = 0; j < 2; j++) begin
                    exp_d0[j] = '0;
                    exp_d1[j] = '0;
                end
            end else if (st && (rs == 0 || k > dk)) begin
                rs = k + 1;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        srstn   = 1'b1;
        $display("run sel=%0d hold=%0d pulse=%0d rst=%0d writes0=%0d writes1=%0d dones=%0d",
                 sel, hold, pulse_at, rst_at, writes0, writes1, dones);
    endtask

    int w0, w1, nd;

    initial begin
        srstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        res0 = '0; res1 = '0;
        for (int j = 0; j < 2; j++) begin
            exp_d0[j] = '0;
            exp_d1[j] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst wen_a0",   wen0_a,  1'b1);
        chk("rst wen_a1",   wen1_a,  1'b1);
        chk("rst waddr_a0", addr0_a, 127);
        chk("rst waddr_a1", addr1_a, 127);
        chk("rst wdata_a0", data0_a, 0);
        chk("rst wdata_a1", data1_a, 0);
        chk("rst busy",     busy_a,  1'b0);
        chk("rst done",     done_a,  1'b0);
        chk("rst b wen_a0", wen0_b,  1'b1);
        chk("rst b busy",   busy_b,  1'b0);
        srstn = 1'b1;
        drive_results();

        // single run at defaults
        run(0, 16, 99, 4, 1, -1, -1, 130, w0, w1, nd);
        chk("single writes0", w0, 99);
        chk("single writes1", w1, 99);
        chk("single dones",   nd, 1);

        // start held high: back-to-back runs, second accepted the cycle after done
        run(0, 16, 99, 4, 200, -1, -1, 250, w0, w1, nd);
        chk("held writes0", w0, 198);
        chk("held writes1", w1, 198);
        chk("held dones",   nd, 2);

        // start pulse during WRITE is ignored
        run(0, 16, 99, 4, 1, 60, -1, 130, w0, w1, nd);
        chk("pulse writes0", w0, 99);
        chk("pulse writes1", w1, 99);
        chk("pulse dones",   nd, 1);

        // reset while s=50, then a clean run
        run(0, 16, 99, 4, 1, -1, 67, 100, w0, w1, nd);
        chk("rst-mid writes0", w0, 50);
        chk("rst-mid writes1", w1, 46);
        chk("rst-mid dones",   nd, 0);
        run(0, 16, 99, 4, 1, -1, -1, 130, w0, w1, nd);
        chk("after-rst writes0", w0, 99);
        chk("after-rst writes1", w1, 99);
        chk("after-rst dones",   nd, 1);

        // ARRAY_LAT=1, NUM_WORDS=4, GROUP_SKEW=0 instance
        run(1, 1, 4, 0, 1, -1, -1, 12, w0, w1, nd);
        chk("small writes0", w0, 4);
        chk("small writes1", w1, 4);
        chk("small dones",   nd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
